// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath and its coefficient loader.
//   N_TAPS  : number of filter taps
//   TAP_W   : tap width (Q1.15 signed, matching the fir >>15 scaling)
//   tap_t   : one coefficient word
//   loader_state_t : coefficient loader FSM states
package fir_pkg;

    localparam int N_TAPS = 10;
    localparam int TAP_W  = 16;

    typedef logic [TAP_W-1:0] tap_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        PEND  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/fir_tap_bank.sv
// N x W coefficient register bank.
//   clock, reset : system clock, synchronous active-high reset (clears bank)
//   wr_en        : write wr_data into entry wr_idx
//   wr_idx       : entry to write
//   wr_data      : word to write
//   load_en      : replace every entry with load_data at one edge
//   load_data    : bulk-load source
//   q            : current bank contents
// A bulk load takes priority over a single-entry write.
module fir_tap_bank
    import fir_pkg::*;
#(
    parameter int N  = N_TAPS,
    parameter int W  = TAP_W,
    parameter int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic          load_en,
    input  logic [W-1:0]  load_data [N-1:0],
    output logic [W-1:0]  q         [N-1:0]
);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) q[i] <= '0;
        end else if (load_en) begin
            for (int i = 0; i < N; i++) q[i] <= load_data[i];
        end else if (wr_en) begin
            // Decoded compare keeps an out-of-range index from touching anything.
            for (int i = 0; i < N; i++) begin
                if (wr_idx == IW'(i)) q[i] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/fir_tap_loader.sv
// Coefficient writer for the fir datapath. Tap words arrive over a
// valid/ready stream into a shadow bank; a correctly framed load of exactly
// N words is copied atomically into the active bank on a swap_en strobe.
//   clock, reset  : system clock, synchronous active-high reset
//   cfg_valid     : cfg_data/cfg_last valid this cycle
//   cfg_ready     : loader accepts a beat this cycle
//   cfg_data      : tap word, first beat of a frame is taps[0]
//   cfg_last      : final beat of a frame
//   swap_en       : sample-boundary strobe
//   taps          : active coefficient bank driving the fir
//   taps_valid    : set once the first good frame has been committed
//   taps_updated  : one-cycle pulse on the cycle after a commit
//   load_err      : one-cycle pulse when a malformed frame is dropped
//   busy          : high in LOAD, DRAIN and PEND
//
// Handshake: a beat transfers on a rising edge where cfg_valid && cfg_ready.
// cfg_ready depends on state only (low only in PEND), never on cfg_valid;
// a producer may hold cfg_valid/cfg_data/cfg_last steady until it transfers.
//
// state_q is the FSM state register, kept as a named signal so checkers can
// bind to it.
module fir_tap_loader
    import fir_pkg::*;
#(
    parameter int N = N_TAPS,
    parameter int W = TAP_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_data,
    input  logic         cfg_last,
    input  logic         swap_en,
    output logic [W-1:0] taps [N-1:0],
    output logic         taps_valid,
    output logic         taps_updated,
    output logic         load_err,
    output logic         busy
);

    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    loader_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          accept;
    logic          shadow_wr;
    logic          commit;
    logic          err_d;
    logic [W-1:0]  shadow [N-1:0];
    logic [W-1:0]  zero_bank [N-1:0];

    assign cfg_ready = (state_q != PEND);
    assign busy      = (state_q != IDLE);
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        for (int i = 0; i < N; i++) zero_bank[i] = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            taps_valid   <= 1'b0;
            taps_updated <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            taps_valid   <= taps_valid | commit;
            taps_updated <= commit;
            load_err     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_wr = 1'b0;
        commit    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shadow_wr = 1'b1;
                    if (cfg_last) begin
                        // N >= 2, so a one-beat frame is always short.
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d   = IW'(1);
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    shadow_wr = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = cfg_last ? PEND : DRAIN;
                    end else if (cfg_last) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DRAIN: begin
                // Overlong frame: swallow beats up to cfg_last, then report.
                if (accept && cfg_last) begin
                    err_d   = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (swap_en) begin
                    commit  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    fir_tap_bank #(.N(N), .W(W)) u_shadow (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (shadow_wr),
        .wr_idx    (idx_q),
        .wr_data   (cfg_data),
        .load_en   (1'b0),
        .load_data (zero_bank),
        .q         (shadow)
    );

    fir_tap_bank #(.N(N), .W(W)) u_active (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_data   ('0),
        .load_en   (commit),
        .load_data (shadow),
        .q         (taps)
    );

endmodule

// File: tb/tb_fir_tap_loader.sv
module tb_fir_tap_loader;
    import fir_pkg::*;

    localparam int N = N_TAPS;
    localparam int W = TAP_W;

    // ---------------- clock / reset / DUT ----------------
    logic         clock = 1'b0;
    logic         reset;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_data;
    logic         cfg_last;
    logic         swap_en;
    logic [W-1:0] taps [N-1:0];
    logic         taps_valid;
    logic         taps_updated;
    logic         load_err;
    logic         busy;

    always #5 clock = ~clock;

    fir_tap_loader #(.N(N), .W(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .cfg_last     (cfg_last),
        .swap_en      (swap_en),
        .taps         (taps),
        .taps_valid   (taps_valid),
        .taps_updated (taps_updated),
        .load_err     (load_err),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Frame-level view: collect beats of the current frame; at cfg_last a
    // frame of exactly N words becomes pending, anything else is an error.
    tap_t         frame_q[$];
    tap_t         m_pend [N];
    tap_t         m_taps [N];
    bit           m_pending, m_valid, m_upd, m_err;
    logic [W-1:0] exp_q[$];   // scoreboard: words expected in taps after the next commit

    function automatic logic [4:0] exp_flags();
        // {cfg_ready, busy, taps_valid, taps_updated, load_err}
        return {!m_pending, (frame_q.size() != 0) || m_pending, m_valid, m_upd, m_err};
    endfunction

    task automatic model_clear();
        frame_q.delete();
        m_pending = 0; m_valid = 0; m_upd = 0; m_err = 0;
        for (int i = 0; i < N; i++) begin m_taps[i] = '0; m_pend[i] = '0; end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; drives one cycle, advances the model at the
    // rising edge and returns at the next falling edge.
    task automatic drive_cycle(input bit v, input tap_t d, input bit l, input bit s);
        bit acc;
        cfg_valid = v; cfg_data = d; cfg_last = l; swap_en = s;
        @(posedge clock);
        acc   = v && !m_pending;
        m_upd = 0;
        m_err = 0;
        if (s && m_pending) begin
            for (int i = 0; i < N; i++) m_taps[i] = m_pend[i];
            m_valid   = 1;
            m_pending = 0;
            m_upd     = 1;
        end
        if (acc) begin
            frame_q.push_back(d);
            if (l) begin
                if (frame_q.size() == N) begin
                    for (int i = 0; i < N; i++) m_pend[i] = frame_q[i];
                    m_pending = 1;
                end else begin
                    m_err = 1;
                end
                frame_q.delete();
            end
        end
        @(negedge clock);
        cfg_valid = 0; swap_en = 0; cfg_last = 0;
    endtask

    task automatic do_reset();
        reset = 1; cfg_valid = 0; cfg_last = 0; swap_en = 0; cfg_data = '0;
        @(posedge clock);
        model_clear();
        @(negedge clock);
        reset = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== 5'b10000) begin n_bad++; $display("FAIL reset_flags got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, 5'b10000); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (taps[i] !== '0) begin n_bad++; $display("FAIL reset_taps[%0d] got %h want 0", i, taps[i]); end
        end
    endtask

    task automatic test_good_frame();
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(W'(k + 1));
            drive_cycle(1, W'(k + 1), k == N - 1, 0);
            n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== exp_flags()) begin n_bad++; $display("FAIL good_load_flags beat %0d got %b want %b", k, {cfg_ready, busy, taps_valid, taps_updated, load_err}, exp_flags()); end
        end
        for (int c = 0; c < 3; c++) begin
            drive_cycle(0, '0, 0, 0);
            n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== exp_flags()) begin n_bad++; $display("FAIL good_pend_flags got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, exp_flags()); end
            n_cmp++; if (taps[0] !== '0 || taps[N-1] !== '0) begin n_bad++; $display("FAIL good_early_taps got %h/%h want 0/0", taps[0], taps[N-1]); end
        end
        drive_cycle(0, '0, 0, 1);
        n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== 5'b10110) begin n_bad++; $display("FAIL good_commit_flags got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, 5'b10110); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (taps[i] !== exp_q[i]) begin n_bad++; $display("FAIL good_taps[%0d] got %h want %h", i, taps[i], exp_q[i]); end
        end
        drive_cycle(0, '0, 0, 1);
        n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== 5'b10100) begin n_bad++; $display("FAIL good_single_pulse got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, 5'b10100); end
    endtask

    task automatic test_short_frame();
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1, 16'h0F85, k == 3, 0);
            n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== exp_flags()) begin n_bad++; $display("FAIL short_flags beat %0d got %b want %b", k, {cfg_ready, busy, taps_valid, taps_updated, load_err}, exp_flags()); end
        end
        n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL short_err got %b want 1", load_err); end
        drive_cycle(0, '0, 0, 1);
        n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== 5'b10100) begin n_bad++; $display("FAIL short_after got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, 5'b10100); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (taps[i] !== m_taps[i]) begin n_bad++; $display("FAIL short_keep_taps[%0d] got %h want %h", i, taps[i], m_taps[i]); end
        end
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(16'h1000);
            drive_cycle(1, 16'h1000, k == N - 1, 0);
        end
        drive_cycle(0, '0, 0, 1);
        n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== exp_flags()) begin n_bad++; $display("FAIL short_recover_flags got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, exp_flags()); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (taps[i] !== exp_q[i]) begin n_bad++; $display("FAIL short_recover_taps[%0d] got %h want %h", i, taps[i], exp_q[i]); end
        end
    endtask

    task automatic test_long_frame();
        for (int k = 0; k < 12; k++) begin
            n_cmp++; if (k > 0 && busy !== 1'b1) begin n_bad++; $display("FAIL long_busy beat %0d got %b want 1", k, busy); end
            drive_cycle(1, 16'h7FFF, k == 11, 0);
            n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== exp_flags()) begin n_bad++; $display("FAIL long_flags beat %0d got %b want %b", k, {cfg_ready, busy, taps_valid, taps_updated, load_err}, exp_flags()); end
        end
        n_cmp++; if (load_err !== 1'b1) begin n_bad++; $display("FAIL long_err got %b want 1", load_err); end
        drive_cycle(0, '0, 0, 1);
        drive_cycle(0, '0, 0, 0);
        n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== 5'b10100) begin n_bad++; $display("FAIL long_no_commit got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, 5'b10100); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (taps[i] !== 16'h1000) begin n_bad++; $display("FAIL long_keep_taps[%0d] got %h want 1000", i, taps[i]); end
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(W'(21 + k));
            drive_cycle(1, W'(21 + k), k == N - 1, 0);
        end
        // Beat 99 held valid while the frame is pending: must not transfer.
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_pend got %b want 0", cfg_ready); end
            drive_cycle(1, W'(99), 0, 0);
        end
        drive_cycle(1, W'(99), 0, 1);
        n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== exp_flags()) begin n_bad++; $display("FAIL b2b_commit_flags got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, exp_flags()); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (taps[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_taps[%0d] got %h want %h", i, taps[i], exp_q[i]); end
        end
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(W'(99 + k));
            drive_cycle(1, W'(99 + k), k == N - 1, 0);
            n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== exp_flags()) begin n_bad++; $display("FAIL b2b_new_flags beat %0d got %b want %b", k, {cfg_ready, busy, taps_valid, taps_updated, load_err}, exp_flags()); end
        end
        drive_cycle(0, '0, 0, 1);
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (taps[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_new_taps[%0d] got %h want %h", i, taps[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) drive_cycle(1, 16'h8000, 0, 0);
        do_reset();
        drive_cycle(0, '0, 0, 1);
        n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== 5'b10000) begin n_bad++; $display("FAIL rst_mid_flags got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, 5'b10000); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (taps[i] !== '0) begin n_bad++; $display("FAIL rst_mid_taps[%0d] got %h want 0", i, taps[i]); end
        end
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            tap_t d = W'($urandom);
            exp_q.push_back(d);
            drive_cycle(1, d, k == N - 1, 0);
        end
        drive_cycle(0, '0, 0, 1);
        n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== 5'b10110) begin n_bad++; $display("FAIL rst_mid_commit got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, 5'b10110); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (taps[i] !== exp_q[i]) begin n_bad++; $display("FAIL rst_mid_new_taps[%0d] got %h want %h", i, taps[i], exp_q[i]); end
        end
    endtask

    task automatic test_gapped();
        int cyc = 0;
        for (int rep = 0; rep < 4; rep++) begin
            exp_q.delete();
            for (int k = 0; k < N; k++) begin
                int gap = $urandom_range(0, 3);
                tap_t d = W'($urandom);
                for (int g = 0; g < gap; g++) begin
                    drive_cycle(0, '0, 0, (cyc % 10) == 9);
                    cyc++;
                    n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== exp_flags()) begin n_bad++; $display("FAIL gap_idle_flags got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, exp_flags()); end
                end
                exp_q.push_back(d);
                drive_cycle(1, d, k == N - 1, (cyc % 10) == 9);
                cyc++;
                n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== exp_flags()) begin n_bad++; $display("FAIL gap_beat_flags got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, exp_flags()); end
            end
            // At most one swap period plus one cycle until the commit.
            for (int c = 0; c < 11 && !m_upd; c++) begin
                drive_cycle(0, '0, 0, (cyc % 10) == 9);
                cyc++;
                n_cmp++; if ({cfg_ready, busy, taps_valid, taps_updated, load_err} !== exp_flags()) begin n_bad++; $display("FAIL gap_wait_flags got %b want %b", {cfg_ready, busy, taps_valid, taps_updated, load_err}, exp_flags()); end
            end
            for (int i = 0; i < N; i++) begin
                n_cmp++; if (taps[i] !== exp_q[i]) begin n_bad++; $display("FAIL gap_taps rep %0d [%0d] got %h want %h", rep, i, taps[i], exp_q[i]); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1; cfg_valid = 0; cfg_last = 0; swap_en = 0; cfg_data = '0;
        model_clear();
        test_reset();
        test_good_frame();
        test_short_frame();
        test_long_frame();
        test_back_to_back();
        test_reset_mid();
        test_gapped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
